// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional writeback bypass / hardwired zero register, and a busy scoreboard.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            issue_valid,
  input  logic            issue_wb,
  input  logic [AW-1:0]   rd_issue,
  output logic            issue_ok,
  output logic            hazard,
  input  logic            wer,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] regdata,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic            w_wr_en;
  logic            w_bp1;
  logic            w_bp2;
  logic [NREG-1:0] w_wb_onehot;
  logic [NREG-1:0] w_eff_busy;
  logic            w_set_en;

  assign w_wr_en = wer && !(ZERO_REG && (rd == '0));

  always_comb begin
    w_wb_onehot = '0;
    if (wer) w_wb_onehot[rd] = 1'b1;
  end

  // A same-cycle writeback releases its destination only when bypass exists.
  always_comb begin
    w_eff_busy = r_busy;
    if (BYPASS) w_eff_busy = r_busy & ~w_wb_onehot;
    if (ZERO_REG) w_eff_busy[0] = 1'b0;
  end

  assign w_bp1 = BYPASS && wer && (rd == rs1);
  assign w_bp2 = BYPASS && wer && (rd == rs2);

  always_comb begin
    rv1 = r_regs[rs1];
    if (w_bp1) rv1 = regdata;
    if (ZERO_REG && (rs1 == '0)) rv1 = '0;
  end

  always_comb begin
    rv2 = r_regs[rs2];
    if (w_bp2) rv2 = regdata;
    if (ZERO_REG && (rs2 == '0)) rv2 = '0;
  end

  assign hazard   = issue_valid &&
                    (w_eff_busy[rs1] || w_eff_busy[rs2] ||
                     (issue_wb && w_eff_busy[rd_issue]));
  assign issue_ok = issue_valid && !hazard;
  assign w_set_en = issue_ok && issue_wb && !(ZERO_REG && (rd_issue == '0));
  assign busy_vec = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '{default: '0};
    end else if (w_wr_en) begin
      r_regs[rd] <= regdata;
    end
  end

  // Set follows clear so a newly issued producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (wer) r_busy[rd] <= 1'b0;
      if (w_set_en) r_busy[rd_issue] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: directed stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd_issue = '0, rd = '0;
  logic        issue_valid = 1'b0, issue_wb = 1'b0, wer = 1'b0;
  logic [31:0] regdata = '0;

  logic [31:0] a_rv1, a_rv2, b_rv1, b_rv2, a_busy, b_busy;
  logic        a_ok, a_hz, b_ok, b_hz;

  logic [3:0]  p_rs1 = '0, p_rs2 = '0, p_rd = '0;
  logic        p_wer = 1'b0;
  logic [63:0] p_data = '0;
  logic [63:0] c_rv1, c_rv2;
  logic [15:0] c_busy;
  logic        c_ok, c_hz;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rv1(a_rv1), .rv2(a_rv2),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .rd_issue(rd_issue),
    .issue_ok(a_ok), .hazard(a_hz), .wer(wer), .rd(rd), .regdata(regdata),
    .busy_vec(a_busy));

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rv1(b_rv1), .rv2(b_rv2),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .rd_issue(rd_issue),
    .issue_ok(b_ok), .hazard(b_hz), .wer(wer), .rd(rd), .regdata(regdata),
    .busy_vec(b_busy));

  regfile_sb #(.XLEN(64), .NREG(16), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_c (
    .clk(clk), .rst(rst), .rs1(p_rs1), .rs2(p_rs2), .rv1(c_rv1), .rv2(c_rv2),
    .issue_valid(1'b0), .issue_wb(1'b0), .rd_issue(4'd0),
    .issue_ok(c_ok), .hazard(c_hz), .wer(p_wer), .rd(p_rd), .regdata(p_data),
    .busy_vec(c_busy));

  typedef enum int {
    A_RV1, A_RV2, A_HZ, A_OK, A_BUSY, B_RV1, B_HZ, B_OK, B_BUSY, C_RV1, C_RV2
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input sig_e s, input logic [63:0] v, input string n);
    q.push_back('{sig: s, val: v, name: n});
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.sig)
        A_RV1:  act = {32'd0, a_rv1};
        A_RV2:  act = {32'd0, a_rv2};
        A_HZ:   act = {63'd0, a_hz};
        A_OK:   act = {63'd0, a_ok};
        A_BUSY: act = {32'd0, a_busy};
        B_RV1:  act = {32'd0, b_rv1};
        B_HZ:   act = {63'd0, b_hz};
        B_OK:   act = {63'd0, b_ok};
        B_BUSY: act = {32'd0, b_busy};
        C_RV1:  act = c_rv1;
        C_RV2:  act = c_rv2;
        default: act = 'x;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wb = 1'b0; rd_issue = '0;
    wer = 1'b0; rd = '0; regdata = '0; rs1 = '0; rs2 = '0; rst = 1'b0;
  endtask

  initial begin
    // reset state
    cyc();
    idle(); rs1 = 5'd5; issue_valid = 1'b1;
    expect_v(A_RV1, 0, "reset_rv1");   expect_v(B_RV1, 0, "reset_rv1_nb");
    expect_v(A_BUSY, 0, "reset_busy"); expect_v(A_HZ, 0, "reset_hazard");
    expect_v(A_OK, 1, "reset_issue_ok");

    // write r5, then reset with a competing issue
    cyc(); idle(); wer = 1'b1; rd = 5'd5; regdata = 32'hDEADBEEF;
    cyc(); idle(); rs1 = 5'd5; rst = 1'b1;
    issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = 5'd4;
    expect_v(A_RV1, 32'hDEADBEEF, "r5_written");
    expect_v(B_RV1, 32'hDEADBEEF, "r5_written_nb");
    cyc(); idle(); rs1 = 5'd5;
    expect_v(A_RV1, 0, "r5_cleared"); expect_v(B_RV1, 0, "r5_cleared_nb");
    expect_v(A_BUSY, 0, "rst_dominates_issue");

    // zero register
    cyc(); idle(); wer = 1'b1; rd = '0; regdata = 32'h1234;
    expect_v(A_RV1, 0, "zero_same_cycle"); expect_v(B_RV1, 0, "zero_same_cycle_nb");
    cyc(); idle();
    expect_v(A_RV1, 0, "zero_next"); expect_v(B_RV1, 0, "zero_next_nb");

    // bypass
    cyc(); idle(); wer = 1'b1; rd = 5'd3; regdata = 32'h11;
    cyc(); idle(); wer = 1'b1; rd = 5'd3; regdata = 32'h22; rs1 = 5'd3;
    expect_v(A_RV1, 32'h22, "bypass_rv1"); expect_v(B_RV1, 32'h11, "nobypass_old");
    cyc(); idle(); rs1 = 5'd3;
    expect_v(A_RV1, 32'h22, "after_write"); expect_v(B_RV1, 32'h22, "after_write_nb");

    // RAW stall
    cyc(); idle(); issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = 5'd7;
    expect_v(A_OK, 1, "raw_c0_ok"); expect_v(B_OK, 1, "raw_c0_ok_nb");
    cyc(); idle(); issue_valid = 1'b1; rs2 = 5'd7;
    expect_v(A_BUSY, 32'h80, "raw_busy7"); expect_v(B_BUSY, 32'h80, "raw_busy7_nb");
    expect_v(A_HZ, 1, "raw_c1_hz"); expect_v(A_OK, 0, "raw_c1_ok");
    expect_v(B_HZ, 1, "raw_c1_hz_nb");
    cyc(); idle(); issue_valid = 1'b1; rs2 = 5'd7;
    expect_v(A_HZ, 1, "raw_c2_hz");
    cyc(); idle(); issue_valid = 1'b1; rs2 = 5'd7; wer = 1'b1; rd = 5'd7; regdata = 32'h77;
    expect_v(A_HZ, 0, "raw_c3_hz"); expect_v(A_OK, 1, "raw_c3_ok");
    expect_v(A_RV2, 32'h77, "raw_c3_fwd");
    expect_v(B_HZ, 1, "raw_c3_hz_nb"); expect_v(B_OK, 0, "raw_c3_ok_nb");
    cyc(); idle();
    expect_v(A_BUSY, 0, "raw_c4_busy"); expect_v(B_BUSY, 0, "raw_c4_busy_nb");

    // WAW with simultaneous set/clear
    cyc(); idle(); issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = 5'd9;
    expect_v(A_OK, 1, "waw_first_ok");
    cyc(); idle(); issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = 5'd9;
    wer = 1'b1; rd = 5'd9; regdata = 32'h99;
    expect_v(A_OK, 1, "waw_setclr_ok"); expect_v(A_HZ, 0, "waw_setclr_hz");
    expect_v(B_OK, 0, "waw_setclr_ok_nb");
    cyc(); idle(); issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = 5'd9;
    expect_v(A_BUSY, 32'h200, "set_wins_busy"); expect_v(B_BUSY, 0, "clear_only_nb");
    expect_v(A_HZ, 1, "waw_hazard"); expect_v(B_HZ, 0, "waw_free_nb");

    // issuing to r0 never sets busy; writeback to idle reg keeps busy 0
    cyc(); idle(); issue_valid = 1'b1; issue_wb = 1'b1; rd_issue = '0;
    wer = 1'b1; rd = 5'd12; regdata = 32'hC;
    expect_v(A_OK, 1, "r0_issue_ok");
    expect_v(B_BUSY, 32'h200, "nb_busy9");
    cyc(); idle(); rs1 = 5'd12;
    expect_v(A_BUSY, 32'h200, "r0_not_busy"); expect_v(B_BUSY, 32'h200, "r0_not_busy_nb");
    expect_v(A_RV1, 32'hC, "idle_wb_data");

    // reset mid-operation, then late writeback
    cyc(); idle(); rst = 1'b1;
    cyc(); idle(); wer = 1'b1; rd = 5'd9; regdata = 32'hAB;
    expect_v(A_BUSY, 0, "midrst_busy"); expect_v(B_BUSY, 0, "midrst_busy_nb");
    cyc(); idle(); rs1 = 5'd9;
    expect_v(A_RV1, 32'hAB, "late_wb_data"); expect_v(B_RV1, 32'hAB, "late_wb_data_nb");
    expect_v(A_BUSY, 0, "late_wb_busy");

    // XLEN=64, NREG=16
    cyc(); idle(); p_wer = 1'b1; p_rd = 4'd15; p_data = 64'hFFFF_FFFF_0000_0001; p_rs2 = 4'd15;
    expect_v(C_RV2, 64'hFFFF_FFFF_0000_0001, "w64_bypass");
    cyc(); p_wer = 1'b0; p_data = '0; p_rs1 = 4'd14;
    expect_v(C_RV2, 64'hFFFF_FFFF_0000_0001, "w64_readback");
    expect_v(C_RV1, 0, "w64_other_reg");

    cyc(); idle();
    @(posedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
